// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
package dcache_pkg;

  // Controller states: idle/lookup, line refill, refill response, store write-through
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_RESP   = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  localparam int BYTE_BITS      = 2;
  localparam int OFFSET_BITS    = 2;
  localparam int WORDS_PER_LINE = 4;

  // Tag width left over once the index, word offset and byte offset are removed
  function automatic int tag_width(input int addr_w, input int index_bits);
    return addr_w - index_bits - OFFSET_BITS - BYTE_BITS;
  endfunction

  // Number of cache lines addressed by the index field
  function automatic int line_count(input int index_bits);
    return 1 << index_bits;
  endfunction

endpackage

// File: rtl/dcache_dm_if.sv
// CPU-side request/response and data_ram-side bus of the data cache.
// master = environment (MEM stage + data_ram), slave = the cache.
interface dcache_dm_if #(parameter int ADDR_W = 32);
  logic              cpu_req;
  logic [3:0]        cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wen;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done,
    input  mem_addr, mem_wen, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done,
    output mem_addr, mem_wen, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache. Lookup is combinational;
// refill writes one line word per cycle, stores merge bytes into a hit word.
module dcache_array import dcache_pkg::*; #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 26
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear_all,
  input  logic [INDEX_BITS-1:0]  lk_index,
  input  logic [TAG_BITS-1:0]    lk_tag,
  input  logic [OFFSET_BITS-1:0] lk_offset,
  output logic                   hit,
  output logic [31:0]            rd_word,
  input  logic                   fill_we,
  input  logic [INDEX_BITS-1:0]  fill_index,
  input  logic [TAG_BITS-1:0]    fill_tag,
  input  logic [OFFSET_BITS-1:0] fill_offset,
  input  logic [31:0]            fill_data,
  input  logic                   tag_we,
  input  logic                   merge_we,
  input  logic [3:0]             merge_be,
  input  logic [31:0]            merge_data
);

  localparam int LINES = line_count(INDEX_BITS);

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES][WORDS_PER_LINE];

  assign hit     = valid[lk_index] && (tag_mem[lk_index] == lk_tag);
  assign rd_word = data_mem[lk_index][lk_offset];

  // Valid bits: cleared by reset or flush, set when a refill completes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (tag_we) begin
      valid[fill_index] <= 1'b1;
    end
  end

  // Tag store, written together with the valid bit at the end of a refill
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[fill_index] <= fill_tag;
    end
  end

  // Data store: whole-word refill writes or byte-enable merge of a store hit
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[fill_index][fill_offset] <= fill_data;
    end else if (merge_we) begin
      for (int b = 0; b < 4; b++) begin
        if (merge_be[b]) begin
          data_mem[lk_index][lk_offset][8*b +: 8] <= merge_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits answer in one cycle, read misses refill a 4-word line from data_ram.
module dcache_dm import dcache_pkg::*; #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic        clk,
  input  logic        resetn,
  dcache_dm_if.slave  bus,
  input  logic        flush,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int TAG_BITS  = tag_width(ADDR_W, INDEX_BITS);
  localparam int INDEX_LSB = OFFSET_BITS + BYTE_BITS;
  localparam int TAG_LSB   = INDEX_LSB + INDEX_BITS;

  state_t                 state;
  logic [2:0]             cyc;
  logic [ADDR_W-1:0]      addr_q;
  logic                   done_q;
  logic [31:0]            rdata_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [3:0]             mem_wen_q;
  logic [31:0]            mem_wdata_q;

  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_index;
  logic [OFFSET_BITS-1:0] req_offset;
  logic [TAG_BITS-1:0]    line_tag;
  logic [INDEX_BITS-1:0]  line_index;
  logic [OFFSET_BITS-1:0] want_offset;
  logic [OFFSET_BITS-1:0] fill_offset;
  logic [OFFSET_BITS-1:0] next_word;
  logic [2:0]             cyc_m1;

  logic                   hit;
  logic [31:0]            rd_word;
  logic                   accept;
  logic                   is_load;
  logic                   fill_we;
  logic                   tag_we;
  logic                   merge_we;
  logic                   clear_all;

  assign req_tag     = bus.cpu_addr[ADDR_W-1:TAG_LSB];
  assign req_index   = bus.cpu_addr[TAG_LSB-1:INDEX_LSB];
  assign req_offset  = bus.cpu_addr[INDEX_LSB-1:BYTE_BITS];
  assign line_tag    = addr_q[ADDR_W-1:TAG_LSB];
  assign line_index  = addr_q[TAG_LSB-1:INDEX_LSB];
  assign want_offset = addr_q[INDEX_LSB-1:BYTE_BITS];

  // cyc counts REFILL cycles; data for word (cyc-1) arrives in cycle cyc
  assign cyc_m1      = cyc - 3'd1;
  assign fill_offset = cyc_m1[OFFSET_BITS-1:0];
  assign next_word   = cyc[OFFSET_BITS-1:0] + OFFSET_BITS'(1);

  // A request is taken only in IDLE, never on the cycle its predecessor completes
  assign accept    = (state == S_IDLE) && !flush && bus.cpu_req && !done_q;
  assign is_load   = (bus.cpu_wen == 4'b0000);
  assign clear_all = (state == S_IDLE) && flush;
  assign fill_we   = (state == S_REFILL) && (cyc != 3'd0);
  assign tag_we    = (state == S_REFILL) && (cyc == 3'd4);
  assign merge_we  = accept && !is_load && hit;

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk         (clk),
    .resetn      (resetn),
    .clear_all   (clear_all),
    .lk_index    (req_index),
    .lk_tag      (req_tag),
    .lk_offset   (req_offset),
    .hit         (hit),
    .rd_word     (rd_word),
    .fill_we     (fill_we),
    .fill_index  (line_index),
    .fill_tag    (line_tag),
    .fill_offset (fill_offset),
    .fill_data   (bus.mem_rdata),
    .tag_we      (tag_we),
    .merge_we    (merge_we),
    .merge_be    (bus.cpu_wen),
    .merge_data  (bus.cpu_wdata)
  );

  assign bus.cpu_done  = done_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Controller FSM with registered CPU/memory outputs and hit/miss counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cyc         <= 3'd0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 4'b0000;
      mem_wdata_q <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      done_q    <= 1'b0;
      mem_wen_q <= 4'b0000;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q <= bus.cpu_addr;
            if (is_load) begin
              if (hit) begin
                done_q  <= 1'b1;
                rdata_q <= rd_word;
                hit_cnt <= hit_cnt + 32'd1;
              end else begin
                miss_cnt   <= miss_cnt + 32'd1;
                state      <= S_REFILL;
                cyc        <= 3'd0;
                mem_addr_q <= {bus.cpu_addr[ADDR_W-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
              end
            end else begin
              state       <= S_WRITE;
              done_q      <= 1'b1;
              mem_addr_q  <= bus.cpu_addr;
              mem_wen_q   <= bus.cpu_wen;
              mem_wdata_q <= bus.cpu_wdata;
            end
          end
        end
        S_REFILL: begin
          if (cyc < 3'd3) begin
            mem_addr_q <= {addr_q[ADDR_W-1:INDEX_LSB], next_word, {BYTE_BITS{1'b0}}};
          end
          if ((cyc != 3'd0) && (fill_offset == want_offset)) begin
            rdata_q <= bus.mem_rdata;
          end
          if (cyc == 3'd4) begin
            state  <= S_RESP;
            done_q <= 1'b1;
          end
          cyc <= cyc + 3'd1;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        S_WRITE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: directed scenarios plus randomized
// load/store/flush traffic against a line-level behavioural cache model.
module tb_dcache_dm;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  dcache_dm_if #(.ADDR_W(32)) bus ();

  dcache_dm #(.INDEX_BITS(4), .ADDR_W(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .flush    (flush),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  // data_ram: 256 words, synchronous read one cycle after the address, byte writes
  logic [31:0] ram [256];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_wen[b]) ram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    bus.mem_rdata <= ram[bus.mem_addr[9:2]];
  end

  // Reference model: memory contents, which lines are resident, counters
  logic [31:0] ref_mem [256];
  logic [15:0] ref_valid;
  logic [31:0] ref_tag [16];
  logic [31:0] ref_hits;
  logic [31:0] ref_misses;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One CPU transaction, started at a negedge with the cache idle
  task automatic applyStimulus(input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit with_flush);
    int          idx;
    bit          exp_hit;
    int          exp_lat;
    int          lat;
    int          k;
    bit          done_seen;
    logic [31:0] exp_rdata;
    logic [31:0] base;

    if (with_flush) ref_valid = '0;
    idx       = int'((addr >> 4) & 32'hF);
    exp_hit   = ref_valid[idx] && (ref_tag[idx] == (addr >> 8));
    base      = {addr[31:4], 4'b0000};
    exp_rdata = ref_mem[addr[9:2]];
    if (wen == 4'b0000) begin
      exp_lat = exp_hit ? 1 : 6;
      if (exp_hit) ref_hits++;
      else begin
        ref_misses++;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = addr >> 8;
      end
    end else begin
      exp_lat = 1;
      ref_mem[addr[9:2]] = mergeBytes(ref_mem[addr[9:2]], wdata, wen);
    end
    if (with_flush) exp_lat++;

    bus.cpu_req   = 1'b1;
    bus.cpu_wen   = wen;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    flush         = with_flush;

    lat       = 0;
    done_seen = 0;
    while (!done_seen && lat < 20) begin
      @(negedge clk);
      lat++;
      flush = 1'b0;
      if (bus.cpu_done) begin
        done_seen = 1;
      end else begin
        checkOutput("mem_wen_quiet", {28'b0, bus.mem_wen}, 32'h0);
        if (wen == 4'b0000 && !exp_hit) begin
          k = lat - 1 - (with_flush ? 1 : 0);
          if (k >= 0 && k < 4) checkOutput("refill_addr", bus.mem_addr, base + 32'(k * 4));
        end
      end
    end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    if (done_seen) begin
      if (wen == 4'b0000) begin
        checkOutput("load_rdata", bus.cpu_rdata, exp_rdata);
        checkOutput("load_mem_wen", {28'b0, bus.mem_wen}, 32'h0);
      end else begin
        checkOutput("store_mem_wen", {28'b0, bus.mem_wen}, {28'b0, wen});
        checkOutput("store_mem_addr", bus.mem_addr, addr);
        checkOutput("store_mem_wdata", bus.mem_wdata, wdata);
      end
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", {31'b0, bus.cpu_done}, 32'h0);
    checkOutput("hit_cnt", hit_cnt, ref_hits);
    checkOutput("miss_cnt", miss_cnt, ref_misses);
  endtask

  task automatic doFlush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ref_valid = '0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_done"}, {31'b0, bus.cpu_done}, 32'h0);
    checkOutput({tag, "_rdata"}, bus.cpu_rdata, 32'h0);
    checkOutput({tag, "_mem_wen"}, {28'b0, bus.mem_wen}, 32'h0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    checkOutput({tag, "_hit_cnt"}, hit_cnt, 32'h0);
    checkOutput({tag, "_miss_cnt"}, miss_cnt, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
    end
    ref_mem[8'h10] = 32'h11111111;
    ref_mem[8'h11] = 32'h22222222;
    ref_mem[8'h12] = 32'h33333333;
    ref_mem[8'h13] = 32'h44444444;
    for (int i = 0; i < 256; i++) ram[i] = ref_mem[i];
    ref_valid  = '0;
    ref_hits   = '0;
    ref_misses = '0;
    for (int i = 0; i < 16; i++) ref_tag[i] = '0;

    resetn        = 1'b0;
    flush         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_wen   = 4'b0000;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] directed scenarios");
    applyStimulus(4'b0000, 32'h40, 32'h0, 0);          // cold miss
    applyStimulus(4'b0000, 32'h48, 32'h0, 0);          // hit in the refilled line
    applyStimulus(4'b0011, 32'h44, 32'hAABBCCDD, 0);   // store hit, partial bytes
    applyStimulus(4'b0000, 32'h44, 32'h0, 0);          // merged word 0x2222CCDD
    applyStimulus(4'b0000, 32'h440, 32'h0, 0);         // same index, new tag, evicts
    applyStimulus(4'b0000, 32'h40, 32'h0, 0);          // misses again
    applyStimulus(4'b1111, 32'h800, 32'h5A5A5A5A, 0);  // store miss, no allocate
    applyStimulus(4'b0000, 32'h800, 32'h0, 0);         // still a miss

    // Reset in the middle of a refill
    bus.cpu_req  = 1'b1;
    bus.cpu_wen  = 4'b0000;
    bus.cpu_addr = 32'h140;
    repeat (3) @(negedge clk);
    resetn      = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checkResetState("midrefill_reset");
    resetn     = 1'b1;
    ref_valid  = '0;
    ref_hits   = '0;
    ref_misses = '0;
    applyStimulus(4'b0000, 32'h40, 32'h0, 0);          // miss after reset
    applyStimulus(4'b0000, 32'h40, 32'h0, 0);          // hit
    doFlush();
    applyStimulus(4'b0000, 32'h40, 32'h0, 0);          // miss after flush
    applyStimulus(4'b0000, 32'h40, 32'h0, 1);          // flush beats held request

    $display("[TB] randomized traffic");
    for (int n = 0; n < 250; n++) begin
      a = {22'b0, 2'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 9) == 0) a = {22'b0, 8'($urandom), 2'b00};
      w = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'b0000;
      if ($urandom_range(0, 19) == 0) doFlush();
      applyStimulus(w, a, $urandom, $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the synchronous single-port data_ram.
- MEM stage issues one load/store request and holds it until cpu_done; cache answers read hits in 1 cycle and refills 4-word lines from data_ram on read misses.
- Hit/miss counters exported for the display/debug path.

Parameters:
INDEX_BITS, 4, log2 of number of lines (16 lines); index = addr[3+INDEX_BITS:4]
WORDS_PER_LINE, 4, words per line, fixed; offset = addr[3:2]
ADDR_W, 32, address width; tag = addr[ADDR_W-1:4+INDEX_BITS]

Ports:
clk  in  1  clock, all logic on posedge
resetn  in  1  synchronous active-low reset
cpu_req  in  1  request valid; held stable with wen/addr/wdata until cpu_done
cpu_wen  in  4  byte write enables; 0 = load, nonzero = store
cpu_addr  in  32  byte address (word-aligned; [1:0] ignored)
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid when cpu_done
cpu_done  out  1  one-cycle completion pulse
flush  in  1  invalidate all lines
mem_addr  out  32  data_ram address (word address = mem_addr[9:2])
mem_wen  out  4  data_ram byte write enables
mem_wdata  out  32  data_ram write data
mem_rdata  in  32  data_ram read data, 1 cycle after mem_addr
hit_cnt  out  32  read-hit count
miss_cnt  out  32  read-miss count

Behaviour:
- Reset (resetn=0 at posedge, any state incl. mid-refill): state IDLE, all valid bits 0, cpu_done 0, cpu_rdata 0, mem_wen 0, mem_addr 0, mem_wdata 0, counters 0. Tag/data arrays not cleared.
- States: IDLE, REFILL, RESP, WRITE.
- IDLE, flush=1: all valid bits cleared at that edge; flush has priority, held request waits 1 cycle. flush outside IDLE ignored.
- IDLE, cpu_req & wen==0, hit (valid & tag match), cycle T: cpu_done=1, cpu_rdata=word at T+1; hit_cnt+1; stay IDLE.
- IDLE, load miss at T: miss_cnt+1, go REFILL. Word k (0..3) issued with mem_addr={tag,index,k,2'b00} at T+1+k; mem_rdata captured at T+2+k into line word k. Valid+tag written at edge ending T+5. RESP at T+6: cpu_done=1, cpu_rdata=requested word; then IDLE. Read-miss latency 6 cycles.
- IDLE, store at T: WRITE at T+1: mem_addr=cpu_addr, mem_wen=cpu_wen, mem_wdata=cpu_wdata, cpu_done=1; on hit merge enabled bytes into cached word at same edge; on miss no allocation. Counters unchanged.
- mem_wen=0 in every state except WRITE. cpu_done never asserted two consecutive cycles; next request accepted in IDLE cycle after done.
- Refill replaces line unconditionally (no dirty data, write-through).
- Counters wrap mod 2^32.
- cpu_req deasserted before cpu_done is illegal; behaviour unspecified beyond completing current operation.

Decomposition:
- Package dcache_pkg: state encoding, OFFSET_BITS=2, WORDS_PER_LINE, tag/index width functions.
- Sub-module dcache_array: valid/tag/data storage with combinational lookup, line-word write, byte-merge write, flush-clear. FSM and counters stay in dcache_dm.

Test Plan:
- Cold load 0x40 (mem[0x40]=0x11111111) -> mem_addr 0x40,0x44,0x48,0x4C on T+1..T+4; cpu_done at T+6, cpu_rdata=0x11111111; miss_cnt=1.
- Then load 0x48 (mem=0x33333333) -> cpu_done at T+1, rdata 0x33333333, mem_wen 0, no refill addresses; hit_cnt=1.
- Store 0x44 wen=4'b0011 data 0xAABBCCDD over cached 0x22222222 -> T+1: mem_wen=0011, mem_addr 0x44, cpu_done; later load 0x44 hits with 0x2222CCDD.
- Load 0x440 (same index 4, new tag) -> refill evicts; subsequent load 0x40 misses again (miss_cnt +1).
- Store to uncached 0x800 -> memory written, following load 0x800 is a miss (no allocate).
- resetn low at T+3 of refill -> next cycle IDLE, mem_wen 0, counters 0; load 0x40 misses. flush in IDLE -> prior hit address misses.
